// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } sub_state_t;

endpackage

// File: rtl/full_subtractor_bit.sv
// 1-bit full-subtractor cell: d = a - b - br_in, br_out is the borrow out.
module full_subtractor_bit (
  input  logic a,
  input  logic b,
  input  logic br_in,
  output logic d,
  output logic br_out
);

  assign d      = a ^ b ^ br_in;
  assign br_out = (~a & b) | (~a & br_in) | (b & br_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - borrow_in, LSB first, with valid/ready on both sides.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  sub_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic             br;
  logic             sa;
  logic             sb;
  logic             d;
  logic             br_nxt;

  full_subtractor_bit u_cell (
    .a      (a_sh[0]),
    .b      (b_sh[0]),
    .br_in  (br),
    .d      (d),
    .br_out (br_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      br    <= 1'b0;
      sa    <= 1'b0;
      sb    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            res   <= '0;
            br    <= borrow_in;
            sa    <= a[WIDTH-1];
            sb    <= b[WIDTH-1];
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          res  <= {d, res[WIDTH-1:1]};
          br   <= br_nxt;
          // counter is cleared on exit so it never wraps arithmetically
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign diff       = res;
  assign borrow_out = br;
  assign overflow   = (sa != sb) && (res[WIDTH-1] != sa);

endmodule
